// File: rtl/branch_unit.sv
// Multi-cycle branch resolution unit: IDLE -> RESOLVE (-> LINK for jal).
// Optional return-address stack compiled in with BRANCH_UNIT_RAS_EN.
module branch_unit #(
    parameter int PC_W       = 9,
    parameter int DATA_W     = 32,
    parameter int SIGNED_CMP = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [PC_W-1:0]   pc,
    output logic              taken,
    output logic              link_we,
    output logic [PC_W-1:0]   link_data
);

    typedef enum logic [1:0] {IDLE, RESOLVE, LINK} state_t;

    localparam logic [5:0] OP_J   = 6'd20;
    localparam logic [5:0] OP_JR  = 6'd21;
    localparam logic [5:0] OP_JAL = 6'd22;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic              link_we_q, link_we_d;
    logic [PC_W-1:0]   link_data_q, link_data_d;
    logic [5:0]        opc_q;
    logic [15:0]       off_q;
    logic [DATA_W-1:0] rs_q, rt_q;
    logic              accept;
    logic              eq, lt, br_hit;
    logic [PC_W-1:0]   pc_inc, br_tgt, jmp_tgt, jr_tgt;

    assign accept  = (state_q == IDLE) && instr_valid;
    assign eq      = (rs_q == rt_q);
    assign lt      = (SIGNED_CMP != 0) ? ($signed(rs_q) < $signed(rt_q))
                                       : (rs_q < rt_q);
    assign pc_inc  = pc_q + PC_W'(1);
    assign br_tgt  = pc_inc + PC_W'($signed(off_q));
    assign jmp_tgt = PC_W'(off_q);

`ifdef BRANCH_UNIT_RAS_EN
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q, top_idx;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rsn_q;
    logic             ras_push, ras_pop;
    logic             unused_bits;

    assign unused_bits = ^instruction[20:16];
    assign top_idx  = sp_q - SP_W'(1);
    assign ras_push = (state_q == RESOLVE) && (opc_q == OP_JAL);
    assign ras_pop  = (state_q == RESOLVE) && (opc_q == OP_JR) &&
                      (rsn_q == 5'd31) && (cnt_q != '0);
    assign jr_tgt   = ras_pop ? ras_q[top_idx] : rs_q[PC_W-1:0];

    // Circular buffer: a push past full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (ras_push) begin
            ras_q[sp_q] <= pc_inc;
            sp_q        <= sp_q + SP_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH))
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (ras_pop) begin
            sp_q  <= top_idx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            rsn_q <= instruction[25:21];
    end
`else
    logic unused_bits;

    assign unused_bits = ^instruction[25:16];
    assign jr_tgt      = rs_q[PC_W-1:0];
`endif

    always_comb begin
        br_hit = 1'b0;
        case (opc_q)
            6'd14:   br_hit = eq;
            6'd15:   br_hit = !eq;
            6'd16:   br_hit = !lt && !eq;
            6'd17:   br_hit = !lt;
            6'd18:   br_hit = lt;
            6'd19:   br_hit = lt || eq;
            default: br_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        taken_d     = 1'b0;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        case (state_q)
            IDLE: begin
                if (instr_valid)
                    state_d = RESOLVE;
            end
            RESOLVE: begin
                state_d = IDLE;
                pc_d    = pc_inc;
                case (opc_q)
                    OP_J: begin
                        pc_d    = jmp_tgt;
                        taken_d = 1'b1;
                    end
                    OP_JR: begin
                        pc_d    = jr_tgt;
                        taken_d = 1'b1;
                    end
                    OP_JAL: begin
                        pc_d        = jmp_tgt;
                        taken_d     = 1'b1;
                        link_data_d = pc_inc;
                        state_d     = LINK;
                    end
                    default: begin
                        if (br_hit) begin
                            pc_d    = br_tgt;
                            taken_d = 1'b1;
                        end
                    end
                endcase
            end
            LINK: begin
                link_we_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            taken_q     <= taken_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opc_q <= instruction[31:26];
            off_q <= instruction[15:0];
            rs_q  <= rs_val;
            rt_q  <= rt_val;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign pc          = pc_q;
    assign taken       = taken_q;
    assign link_we     = link_we_q;
    assign link_data   = link_data_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table, corner sequences,
// and random instructions against a transaction-level reference model.
module tb_branch_unit;

    localparam int PCW = 9;
    localparam int M   = 1 << PCW;
    localparam int RD  = 4;

    logic clk, rst, instr_valid, instr_ready, taken, link_we;
    logic [31:0] instruction, rs_val, rt_val;
    logic [PCW-1:0] pc, link_data;

    logic rst1, v1, ready1, taken1, lwe1;
    logic [31:0] ins1, rs1, rt1;
    logic [PCW-1:0] pc1, ld1;

    int total = 0;
    int pass_cnt = 0;

    branch_unit #(.PC_W(PCW), .DATA_W(32), .SIGNED_CMP(0), .RAS_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction),
        .rs_val(rs_val), .rt_val(rt_val), .pc(pc), .taken(taken),
        .link_we(link_we), .link_data(link_data));

    branch_unit #(.PC_W(PCW), .DATA_W(32), .SIGNED_CMP(1), .RAS_DEPTH(RD)) dut_s (
        .clk(clk), .rst(rst1), .instr_valid(v1), .instr_ready(ready1),
        .instruction(ins1), .rs_val(rs1), .rt_val(rt1), .pc(pc1),
        .taken(taken1), .link_we(lwe1), .link_data(ld1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic logic [31:0] enc(input int op, input int rsf,
                                        input int rtf, input int off);
        return {op[5:0], rsf[4:0], rtf[4:0], off[15:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_taken", 32'(taken), 0);
        chk("rst_link_we", 32'(link_we), 0);
        chk("rst_link_data", 32'(link_data), 0);
        chk("rst_ready", 32'(instr_ready), 1);
    endtask

    // Offer one instruction from IDLE and check the whole handshake.
    task automatic apply(input string nm, input logic [31:0] ins,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input int epc, input bit etk, input int elink);
        instr_valid = 1'b1;
        instruction = ins;
        rs_val = rsv;
        rt_val = rtv;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk({nm, "_busy"}, 32'(instr_ready), 0);
        chk({nm, "_taken_lo"}, 32'(taken), 0);
        chk({nm, "_lwe_lo"}, 32'(link_we), 0);
        @(posedge clk); #1;
        chk({nm, "_pc"}, 32'(pc), epc);
        chk({nm, "_taken"}, 32'(taken), 32'(etk));
        if (ins[31:26] == 6'd22) begin
            chk({nm, "_link_busy"}, 32'(instr_ready), 0);
            chk({nm, "_lwe_early"}, 32'(link_we), 0);
            @(posedge clk); #1;
            chk({nm, "_lwe"}, 32'(link_we), 1);
            chk({nm, "_link_data"}, 32'(link_data), elink);
            chk({nm, "_taken_once"}, 32'(taken), 0);
            chk({nm, "_pc_hold"}, 32'(pc), epc);
        end
        chk({nm, "_ready"}, 32'(instr_ready), 1);
    endtask

    int mpc;
    int mras[$];

    // Reference: resolves one instruction from the architectural rules.
    task automatic model(input logic [31:0] ins, input logic [31:0] rsv,
                         input logic [31:0] rtv, output int epc,
                         output bit etk, output int elink);
        int op;
        int nxt;
        bit cond;
        longint a, b, off;
        logic signed [15:0] so;
        op = int'(ins[31:26]);
        so = ins[15:0];
        off = so;
        a = rsv;
        b = rtv;
        nxt = (mpc + 1) % M;
        epc = nxt;
        etk = 0;
        elink = nxt;
        cond = 0;
        case (op)
            14: cond = (a == b);
            15: cond = (a != b);
            16: cond = (a > b);
            17: cond = (a >= b);
            18: cond = (a < b);
            19: cond = (a <= b);
            default: cond = 0;
        endcase
        if (op >= 14 && op <= 19) begin
            if (cond) begin
                epc = int'(((longint'(mpc) + 1 + off) % M + M) % M);
                etk = 1;
            end
        end else if (op == 20) begin
            epc = int'(ins[15:0]) % M;
            etk = 1;
        end else if (op == 21) begin
            epc = int'(rsv % M);
            etk = 1;
`ifdef BRANCH_UNIT_RAS_EN
            if (ins[25:21] == 5'd31 && mras.size() > 0)
                epc = mras.pop_back();
`endif
        end else if (op == 22) begin
            epc = int'(ins[15:0]) % M;
            etk = 1;
`ifdef BRANCH_UNIT_RAS_EN
            mras.push_back(nxt);
            if (mras.size() > RD)
                void'(mras.pop_front());
`endif
        end
        mpc = epc;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic [31:0] rsv;
        logic [31:0] rtv;
        int          epc;
        bit          etk;
        int          elink;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int epc, elink;
        bit etk;
        logic [31:0] ins, rsv, rtv;
        int op, rsf;

        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        rs_val = '0;
        rt_val = '0;
        rst1 = 1'b1;
        v1 = 1'b0;
        ins1 = '0;
        rs1 = '0;
        rt1 = '0;

        tbl[0]  = '{"beq_eq",    enc(14, 1, 2, 3),       5, 5, 4, 1, 0};
        tbl[1]  = '{"bne_eq",    enc(15, 1, 2, 3),       5, 5, 5, 0, 0};
        tbl[2]  = '{"bgt_uns",   enc(16, 1, 2, 10),      32'hFFFF_FFFF, 1, 16, 1, 0};
        tbl[3]  = '{"bge_back",  enc(17, 1, 2, 16'hFFFE), 1, 1, 15, 1, 0};
        tbl[4]  = '{"blt_nt",    enc(18, 1, 2, 5),       2, 1, 16, 0, 0};
        tbl[5]  = '{"ble_next",  enc(19, 1, 2, 0),       2, 2, 17, 1, 0};
        tbl[6]  = '{"j_max",     enc(20, 0, 0, 16'h01FF), 0, 0, 511, 1, 0};
        tbl[7]  = '{"other",     enc(5, 0, 0, 16'h0033), 0, 0, 0, 0, 0};
        tbl[8]  = '{"b_wrap",    enc(14, 1, 2, 16'hFFFE), 0, 0, 511, 1, 0};
        tbl[9]  = '{"jr_rs3",    enc(21, 3, 0, 0),       32'h123, 0, 32'h123, 1, 0};
        tbl[10] = '{"jr_trunc",  enc(21, 3, 0, 0),       32'hFFFF_FE05, 0, 5, 1, 0};
        tbl[11] = '{"j_trunc",   enc(20, 0, 0, 16'hFE10), 0, 0, 16, 1, 0};
        tbl[12] = '{"j_7",       enc(20, 0, 0, 7),       0, 0, 7, 1, 0};
        tbl[13] = '{"jal_40",    enc(22, 0, 0, 16'h40),  0, 0, 32'h40, 1, 8};

        do_reset();
        foreach (tbl[i])
            apply(tbl[i].nm, tbl[i].ins, tbl[i].rsv, tbl[i].rtv,
                  tbl[i].epc, tbl[i].etk, tbl[i].elink);

        // Reset from a non-zero state (link_data holds 8 here).
        do_reset();

        // Reset during RESOLVE abandons the jump.
        apply("j_33", enc(20, 0, 0, 16'h33), 0, 0, 32'h33, 1, 0);
        instr_valid = 1'b1;
        instruction = enc(20, 0, 0, 16'h20);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rres_pc", 32'(pc), 0);
        chk("rres_taken", 32'(taken), 0);
        chk("rres_ready", 32'(instr_ready), 1);
        @(posedge clk); #1;
        chk("rres_pc_after", 32'(pc), 0);
        chk("rres_taken_after", 32'(taken), 0);

        // Reset during LINK suppresses the write strobe.
        apply("j_11", enc(20, 0, 0, 16'h11), 0, 0, 32'h11, 1, 0);
        instr_valid = 1'b1;
        instruction = enc(22, 0, 0, 16'h40);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("rlink_pc", 32'(pc), 32'h40);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rlink_lwe", 32'(link_we), 0);
        chk("rlink_pc0", 32'(pc), 0);
        chk("rlink_ld0", 32'(link_data), 0);
        @(posedge clk); #1;
        chk("rlink_lwe_after", 32'(link_we), 0);

        // Reset wins over an accept in the same cycle.
        apply("j_5", enc(20, 0, 0, 5), 0, 0, 5, 1, 0);
        rst = 1'b1;
        instr_valid = 1'b1;
        instruction = enc(20, 0, 0, 16'h20);
        @(posedge clk); #1;
        rst = 1'b0;
        instr_valid = 1'b0;
        chk("racc_ready", 32'(instr_ready), 1);
        @(posedge clk); #1;
        chk("racc_pc", 32'(pc), 0);
        chk("racc_taken", 32'(taken), 0);
        @(posedge clk); #1;
        chk("racc_pc2", 32'(pc), 0);

        // Signed compare instance.
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("s_rst_pc", 32'(pc1), 0);
        chk("s_rst_ready", 32'(ready1), 1);
        v1 = 1'b1;
        ins1 = enc(16, 1, 2, 10);
        rs1 = 32'hFFFF_FFFF;
        rt1 = 1;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        chk("s_bgt_pc", 32'(pc1), 1);
        chk("s_bgt_taken", 32'(taken1), 0);
        v1 = 1'b1;
        ins1 = enc(18, 1, 2, 4);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        chk("s_blt_pc", 32'(pc1), 6);
        chk("s_blt_taken", 32'(taken1), 1);

        // Five calls then five returns through r31.
        do_reset();
        for (int k = 0; k < 5; k++)
            apply($sformatf("call%0d", k), enc(22, 0, 0, 16 * (k + 1)), 0, 0,
                  16 * (k + 1), 1, (k == 0) ? 1 : 16 * k + 1);
        for (int k = 0; k < 5; k++) begin
`ifdef BRANCH_UNIT_RAS_EN
            epc = (k < 4) ? 16 * (4 - k) + 1 : 32'h55;
`else
            epc = 32'h55;
`endif
            apply($sformatf("ret%0d", k), enc(21, 31, 0, 0), 32'h55, 0,
                  epc, 1, 0);
        end

        // Random instructions against the reference model.
        do_reset();
        mpc = 0;
        mras.delete();
        repeat (400) begin
            op = $urandom_range(12, 23);
            rsf = ($urandom_range(0, 1) == 1) ? 31 : $urandom_range(0, 31);
            ins = enc(op, rsf, $urandom_range(0, 31), $urandom_range(0, 65535));
            rsv = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 3);
            rtv = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 3);
            model(ins, rsv, rtv, epc, etk, elink);
            apply($sformatf("rnd_op%0d", op), ins, rsv, rtv, epc, etk, elink);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
